// File: rtl/instr_fetch_stage.sv
// ============================================================================
// instr_fetch_stage
// ----------------------------------------------------------------------------
// Instruction fetch stage of the RISC-V core. Owns the program counter, issues
// one word read at a time to instruction memory (at most one outstanding
// request), and buffers the returned instruction toward decode. Taken-branch
// redirects from execute retarget the PC and discard any fetch they make
// stale, whether it is still in flight or already buffered.
//
// Ports:
//   clk          in   1   single clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   imem_req     out  1   read request (accepted by memory the same cycle)
//   imem_addr    out  32  word address of the request (current pc)
//   imem_rvalid  in   1   read response valid
//   imem_rdata   in   32  instruction word returned by memory
//   redirect     in   1   taken branch from execute
//   redirect_pc  in   32  branch target (bits [1:0] ignored)
//   id_valid     out  1   buffered instruction available to decode
//   id_ready     in   1   decode accepts the instruction this cycle
//   id_instr     out  32  buffered instruction
//   id_pc        out  32  pc of id_instr
//   id_opcode    out  7   id_instr[6:0], feeds the main control unit
// ============================================================================
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode
);

    // S_REQ  : issue a request for pc
    // S_WAIT : request in flight, waiting for the response
    // S_HOLD : instruction buffered, waiting for decode to take it
    // S_DROP : request in flight but made stale by a redirect; swallow it
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] id_instr_nxt;
    logic [31:0] id_pc_nxt;
    logic        id_valid_nxt;
    logic [31:0] target_pc;

    // Branch targets are forced to word alignment so pc[1:0] stays 00.
    assign target_pc = {redirect_pc[31:2], 2'b00};

    // A redirect in S_REQ suppresses the request so the stale pc is never read.
    assign imem_req  = (state == S_REQ) && !redirect;
    assign imem_addr = pc;
    assign id_opcode = id_instr[6:0];

    // State and datapath registers. Reset is asynchronous so the stage drops
    // back to RESET_PC the moment rst rises, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= {RESET_PC[31:2], 2'b00};
            id_instr <= NOP_INSTR;
            id_pc    <= 32'h0000_0000;
            id_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            id_instr <= id_instr_nxt;
            id_pc    <= id_pc_nxt;
            id_valid <= id_valid_nxt;
        end
    end

    // Next-state and next-register logic. Every register holds by default;
    // each state only overrides what it actually changes. Responses arriving
    // in S_REQ or S_HOLD cannot belong to a live request and are ignored.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        id_instr_nxt = id_instr;
        id_pc_nxt    = id_pc;
        id_valid_nxt = id_valid;

        unique case (state)
            S_REQ: begin
                if (redirect) begin
                    pc_nxt = target_pc;
                end else begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect) begin
                    // With the response already here it can be dropped on the
                    // spot; otherwise it must be swallowed later in S_DROP.
                    pc_nxt    = target_pc;
                    state_nxt = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    id_instr_nxt = imem_rdata;
                    id_pc_nxt    = pc;
                    id_valid_nxt = 1'b1;
                    pc_nxt       = pc + 32'd4;
                    state_nxt    = S_HOLD;
                end
            end

            S_HOLD: begin
                // A same-cycle handshake with decode is flushed downstream by
                // the same redirect, so redirect takes priority over id_ready.
                if (redirect) begin
                    id_valid_nxt = 1'b0;
                    pc_nxt       = target_pc;
                    state_nxt    = S_REQ;
                end else if (id_ready) begin
                    id_valid_nxt = 1'b0;
                    state_nxt    = S_REQ;
                end
            end

            S_DROP: begin
                if (redirect) begin
                    pc_nxt = target_pc;
                end
                if (imem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ============================================================================
// tb_instr_fetch_stage
// ----------------------------------------------------------------------------
// Directed bench for instr_fetch_stage. Instruction memory is played by hand:
// each step drives the inputs for one cycle shortly after the rising edge and
// then checks the outputs against hand-computed values.
// ============================================================================
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    int compareCount = 0;
    int failCount    = 0;

    instr_fetch_stage #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_opcode  (id_opcode)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive all DUT inputs for the current cycle, then let combinational
    // outputs settle before any check.
    task automatic applyStimulus(input logic rv, input logic [31:0] rd,
                                 input logic redir, input logic [31:0] rpc,
                                 input logic rdy);
        imem_rvalid = rv;
        imem_rdata  = rd;
        redirect    = redir;
        redirect_pc = rpc;
        id_ready    = rdy;
        #1;
    endtask

    // One comparison; a failure is counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Full REQ / WAIT / HOLD fetch with 1-cycle memory and decode ready in
    // the HOLD cycle. Starts just after an edge with the DUT in S_REQ.
    task automatic fetchOne(input logic [31:0] addr, input logic [31:0] data,
                            input logic [6:0] opcode);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("req_issued", {31'b0, imem_req}, 32'd1);
        checkOutput("req_addr", imem_addr, addr);
        checkOutput("no_valid_in_req", {31'b0, id_valid}, 32'd0);
        stepCycle();
        applyStimulus(1'b1, data, 1'b0, 32'h0, 1'b0);
        checkOutput("no_req_in_wait", {31'b0, imem_req}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("valid_in_hold", {31'b0, id_valid}, 32'd1);
        checkOutput("hold_pc", id_pc, addr);
        checkOutput("hold_instr", id_instr, data);
        checkOutput("hold_opcode", {25'b0, id_opcode}, {25'b0, opcode});
        stepCycle();
    endtask

    initial begin
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("rst_instr", id_instr, 32'h0000_0013);
        checkOutput("rst_opcode", {25'b0, id_opcode}, 32'h0000_0013);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0);

        // Reset release, back-to-back fetches of 0x0 .. 0xC.
        rst = 1'b0;
        fetchOne(32'h0000_0000, 32'h0000_0013, 7'h13);
        fetchOne(32'h0000_0004, 32'h0050_0093, 7'h13);
        fetchOne(32'h0000_0008, 32'h0010_0113, 7'h13);
        fetchOne(32'h0000_000C, 32'h0000_0013, 7'h13);

        // Fetch 0x10 and stall decode for 5 cycles; a stray response in
        // S_HOLD must not disturb the buffer.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("stall_req_addr", imem_addr, 32'h0000_0010);
        stepCycle();
        applyStimulus(1'b1, 32'h00A1_2023, 1'b0, 32'h0, 1'b0);
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 2, 32'hBAD0_BAD0, 1'b0, 32'h0, 1'b0);
            checkOutput("stall_valid", {31'b0, id_valid}, 32'd1);
            checkOutput("stall_instr", id_instr, 32'h00A1_2023);
            checkOutput("stall_pc", id_pc, 32'h0000_0010);
            checkOutput("stall_opcode", {25'b0, id_opcode}, 32'h0000_0023);
            checkOutput("stall_no_req", {31'b0, imem_req}, 32'd0);
            stepCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("stall_release_valid", {31'b0, id_valid}, 32'd1);
        stepCycle();

        // Request to 0x14, redirect to 0x103 while waiting on 3-cycle memory.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("after_stall_addr", imem_addr, 32'h0000_0014);
        checkOutput("after_stall_req", {31'b0, imem_req}, 32'd1);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b0);
        checkOutput("wait_redir_no_req", {31'b0, imem_req}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("drop_valid0", {31'b0, id_valid}, 32'd0);
        checkOutput("drop_no_req", {31'b0, imem_req}, 32'd0);
        stepCycle();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        checkOutput("drop_valid1", {31'b0, id_valid}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("drop_done_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("drop_done_req", {31'b0, imem_req}, 32'd1);
        checkOutput("drop_done_addr", imem_addr, 32'h0000_0100);
        stepCycle();

        // Fetch 0x100, then redirect to 0x200 in S_HOLD together with id_ready.
        applyStimulus(1'b1, 32'h0000_0513, 1'b0, 32'h0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b1);
        checkOutput("hold_redir_valid", {31'b0, id_valid}, 32'd1);
        checkOutput("hold_redir_pc", id_pc, 32'h0000_0100);
        stepCycle();

        // Now in S_REQ at 0x200: redirect here suppresses the request.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        checkOutput("hold_redir_flush", {31'b0, id_valid}, 32'd0);
        checkOutput("hold_redir_addr", imem_addr, 32'h0000_0200);
        checkOutput("req_redir_no_req", {31'b0, imem_req}, 32'd0);
        stepCycle();

        // Wrap-around fetch at 0xFFFF_FFFC, next request to 0x0.
        fetchOne(32'hFFFF_FFFC, 32'h0000_0093, 7'h13);

        // Redirect to 0x40 in S_WAIT coinciding with the response.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
        checkOutput("wrap_req", {31'b0, imem_req}, 32'd1);
        stepCycle();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0040, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("coinc_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("coinc_req", {31'b0, imem_req}, 32'd1);
        checkOutput("coinc_addr", imem_addr, 32'h0000_0040);
        stepCycle();

        // Asynchronous reset pulse mid-S_WAIT, then a stray response in S_REQ.
        rst = 1'b1;
        #1;
        checkOutput("async_rst_addr", imem_addr, 32'h0000_0000);
        checkOutput("async_rst_valid", {31'b0, id_valid}, 32'd0);
        checkOutput("async_rst_id_pc", id_pc, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_req", {31'b0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr, 32'h0000_0000);
        stepCycle();
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
        checkOutput("stray_ignored", {31'b0, id_valid}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("post_rst_valid", {31'b0, id_valid}, 32'd1);
        checkOutput("post_rst_instr", id_instr, 32'h0050_0093);
        checkOutput("post_rst_pc", id_pc, 32'h0000_0000);
        stepCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_next_addr", imem_addr, 32'h0000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
